// File: rtl/frequency_pkg.sv
// Shared definitions for the FSK generator/analyzer pair: state encoding and
// tick-count helpers derived from clock and tone rates.
package frequency_pkg;

  typedef enum logic {StIdle, StSend} state_e;

  function automatic int unsigned half_ticks(input int unsigned clock_hz,
                                             input int unsigned tone_hz);
    return clock_hz / (2 * tone_hz);
  endfunction

  function automatic int unsigned bit_ticks(input int unsigned clock_hz,
                                            input int unsigned rate);
    return clock_hz / rate;
  endfunction

endpackage

// File: rtl/tone_generator.sv
// Square-wave source: toggles o_sample_out every HALF0 or HALF1 advancing cycles,
// selected by i_sel; i_restart re-zeroes the half-period count without touching the level.
module tone_generator
  import frequency_pkg::*;
#(
  parameter int unsigned HALF0 = 55,
  parameter int unsigned HALF1 = 45
) (
  input  logic i_clock,
  input  logic i_clear,
  input  logic i_advance,
  input  logic i_restart,
  input  logic i_sel,
  output logic o_sample_out
);

  logic [31:0] r_half_cnt;
  logic        r_sample;
  logic [31:0] w_half_last;
  logic        w_hit;

  assign w_half_last = i_sel ? (HALF1 - 32'd1) : (HALF0 - 32'd1);
  assign w_hit       = i_advance & (r_half_cnt == w_half_last);

  // A toggle coinciding with a restart still happens; only the count is cleared.
  always_ff @(posedge i_clock or negedge i_clear) begin
    if (!i_clear) begin
      r_half_cnt <= '0;
      r_sample   <= 1'b0;
    end else begin
      if (w_hit) r_sample <= ~r_sample;
      if (i_restart || w_hit) r_half_cnt <= '0;
      else if (i_advance)     r_half_cnt <= r_half_cnt + 32'd1;
    end
  end

  assign o_sample_out = r_sample;

endmodule

// File: rtl/frequency_generator.sv
// Two-tone FSK transmitter: shifts words out LSB first, one tone per bit for
// BIT_TICKS clocks; back-to-back words are accepted in the last cycle of a word.
module frequency_generator
  import frequency_pkg::*;
#(
  parameter int unsigned FREQUENCY0      = 9000,
  parameter int unsigned FREQUENCY1      = 11000,
  parameter int unsigned BIT_RATE        = 1000,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned CLOCK_FREQUENCY = 50000000
) (
  input  logic                  i_clock,
  input  logic                  i_clear,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  output logic                  o_sample_out,
  output logic                  o_busy,
  output logic                  o_tx_done
);

  localparam int unsigned HALF0     = half_ticks(CLOCK_FREQUENCY, FREQUENCY0);
  localparam int unsigned HALF1     = half_ticks(CLOCK_FREQUENCY, FREQUENCY1);
  localparam int unsigned BIT_TICKS = bit_ticks(CLOCK_FREQUENCY, BIT_RATE);
  localparam int unsigned IDX_W     = $clog2(DATA_WIDTH) + 1;

  if (HALF0 == 0 || HALF1 == 0 || BIT_TICKS == 0) begin : g_bad_ticks
    $error("frequency_generator: HALF0, HALF1 and BIT_TICKS must all be >= 1");
  end
  if (FREQUENCY1 <= FREQUENCY0) begin : g_bad_tones
    $error("frequency_generator: FREQUENCY1 must exceed FREQUENCY0");
  end

  state_e                r_state;
  logic [DATA_WIDTH-1:0] r_shifter;
  logic [31:0]           r_bit_cnt;
  logic [IDX_W-1:0]      r_bit_idx;
  logic                  r_tx_done;

  logic w_run, w_bit_end, w_last, w_xfer;

  assign w_run     = i_enable & (r_state == StSend);
  assign w_bit_end = w_run & (r_bit_cnt == BIT_TICKS - 32'd1);
  assign w_last    = w_bit_end & (r_bit_idx == IDX_W'(DATA_WIDTH - 1));

  assign o_data_ready = i_clear & i_enable & ((r_state == StIdle) | w_last);
  assign w_xfer       = i_data_valid & o_data_ready;

  always_ff @(posedge i_clock or negedge i_clear) begin
    if (!i_clear) begin
      r_state   <= StIdle;
      r_shifter <= '0;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_tx_done <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      if (i_enable) begin
        unique case (r_state)
          StIdle: begin
            if (w_xfer) begin
              r_shifter <= i_data_in;
              r_bit_cnt <= '0;
              r_bit_idx <= '0;
              r_state   <= StSend;
            end
          end
          StSend: begin
            r_bit_cnt <= r_bit_cnt + 32'd1;
            if (w_bit_end) begin
              r_bit_cnt <= '0;
              r_shifter <= r_shifter >> 1;
              r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
            if (w_last) begin
              r_tx_done <= 1'b1;
              if (w_xfer) begin
                r_shifter <= i_data_in;
                r_bit_idx <= '0;
              end else begin
                r_state <= StIdle;
              end
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  tone_generator #(
    .HALF0 (HALF0),
    .HALF1 (HALF1)
  ) u_tone (
    .i_clock      (i_clock),
    .i_clear      (i_clear),
    .i_advance    (w_run),
    .i_restart    (w_bit_end | w_xfer),
    .i_sel        (r_shifter[0]),
    .o_sample_out (o_sample_out)
  );

  assign o_busy    = (r_state == StSend);
  assign o_tx_done = r_tx_done;

endmodule
